// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_controller
//  Purpose  : Direct-mapped, write-back, write-allocate data cache for the
//             MEM stage. Each line holds valid, dirty, tag and LINE_BITS of
//             data. A miss stalls the pipeline while the line is filled. A
//             dirty victim is written back first. The memory side is a
//             line-wide request/ack handshake.
//  Ports    : clk_i, rst_i (async, active-low)
//             cpu_MemRead_i / cpu_MemWrite_i / cpu_addr_i / cpu_data_i : access
//             cpu_data_o / cpu_stall_o : load data and pipeline stall
//             mem_enable_o / mem_write_o / mem_addr_o / mem_data_o : request
//             mem_data_i / mem_ack_i : fill data and completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_controller #(
    parameter int LINES     = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int c_IDX_W  = $clog2(LINES);
    localparam int c_OFF_W  = $clog2(LINE_BITS / 8);
    localparam int c_WORD_W = $clog2(LINE_BITS / 32);
    localparam int c_TAG_W  = 32 - c_IDX_W - c_OFF_W;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MISS       = 3'd1,
        S_WRITEBACK  = 3'd2,
        S_READMISS   = 3'd3,
        S_READMISSOK = 3'd4
    } state_t;

    state_t                 r_state;
    logic [LINES-1:0]       r_valid;
    logic [LINES-1:0]       r_dirty;
    logic [c_TAG_W-1:0]     r_tag  [LINES];
    logic [LINE_BITS-1:0]   r_data [LINES];

    logic                   r_mem_enable;
    logic                   r_mem_write;
    logic [31:0]            r_mem_addr;
    logic [LINE_BITS-1:0]   r_mem_data;

    logic [c_IDX_W-1:0]     w_index;
    logic [c_TAG_W-1:0]     w_tag;
    logic [c_WORD_W-1:0]    w_word;
    logic [LINE_BITS-1:0]   w_line;
    logic                   w_req;
    logic                   w_hit;
    logic                   w_store_hit;
    logic                   w_unused;

    assign w_index     = cpu_addr_i[c_OFF_W +: c_IDX_W];
    assign w_tag       = cpu_addr_i[31 -: c_TAG_W];
    assign w_word      = cpu_addr_i[2 +: c_WORD_W];
    assign w_line      = r_data[w_index];
    assign w_req       = cpu_MemRead_i | cpu_MemWrite_i;
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_store_hit = cpu_MemWrite_i && w_hit;
    // Byte offset within a word is irrelevant for word accesses.
    assign w_unused    = &{1'b0, cpu_addr_i[1:0]};

    assign cpu_stall_o = w_req && !w_hit;
    assign cpu_data_o  = (cpu_MemRead_i && w_hit) ? w_line[w_word*32 +: 32] : 32'h0;

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;

    // Control state, valid/dirty bits and registered memory request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_data   <= '0;
        end else begin
            if (w_store_hit) begin
                r_dirty[w_index] <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_state <= S_MISS;
                    end
                end
                S_MISS: begin
                    r_mem_enable <= 1'b1;
                    if (r_valid[w_index] && r_dirty[w_index]) begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {r_tag[w_index], w_index, {c_OFF_W{1'b0}}};
                        r_mem_data  <= w_line;
                        r_state     <= S_WRITEBACK;
                    end else begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {w_tag, w_index, {c_OFF_W{1'b0}}};
                        r_state     <= S_READMISS;
                    end
                end
                S_WRITEBACK: begin
                    // Enable stays high; the request turns straight into the fetch.
                    if (mem_ack_i) begin
                        r_dirty[w_index] <= 1'b0;
                        r_mem_write      <= 1'b0;
                        r_mem_addr       <= {w_tag, w_index, {c_OFF_W{1'b0}}};
                        r_state          <= S_READMISS;
                    end
                end
                S_READMISS: begin
                    if (mem_ack_i) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_mem_enable     <= 1'b0;
                        r_state          <= S_READMISSOK;
                    end
                end
                S_READMISSOK: begin
                    // Request hits this cycle; a pending store merges via the hit path.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (r_state == S_READMISS && mem_ack_i) begin
            r_data[w_index] <= mem_data_i;
            r_tag[w_index]  <= w_tag;
        end else if (w_store_hit) begin
            r_data[w_index][w_word*32 +: 32] <= cpu_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_controller
//  Purpose  : Directed self-checking bench for dcache_controller. A memory
//             responder acks each request L cycles after it first sees
//             enable. Fetches return word k = 0x1000_0000 + ((addr^0x40)<<8) + k.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    localparam int L = 2;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction log filled by the memory responder.
    int           n_fetch    = 0;
    int           n_wb       = 0;
    int           n_unstable = 0;
    logic [31:0]  fetch_addr = 32'h0;
    logic [31:0]  wb_addr    = 32'h0;
    logic [255:0] wb_data    = '0;

    dcache_controller #(.LINES(16), .LINE_BITS(256)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        base = 32'h1000_0000 + ((a ^ 32'h40) << 8);
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    // Memory responder: counts cycles with enable high, acks on cycle L+1.
    initial begin : memory_model
        int           cnt;
        logic         cur_write;
        logic [31:0]  cur_addr;
        cnt        = 0;
        cur_write  = 1'b0;
        cur_addr   = 32'h0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                cnt       = 0;
            end
            if (!rst_i) begin
                cnt = 0;
            end else if (mem_enable_o) begin
                cnt++;
                if (cnt == 1) begin
                    cur_write = mem_write_o;
                    cur_addr  = mem_addr_o;
                    if (mem_write_o) begin
                        n_wb++;
                        wb_addr = mem_addr_o;
                        wb_data = mem_data_o;
                    end else begin
                        n_fetch++;
                        fetch_addr = mem_addr_o;
                    end
                end else if (mem_write_o !== cur_write || mem_addr_o !== cur_addr) begin
                    n_unstable++;
                end
                if (cnt == L + 1) begin
                    mem_ack_i = 1'b1;
                    if (!mem_write_o) mem_data_i = mem_line(mem_addr_o);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU access: counts stall cycles, returns load data of the hit cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output int stalls, output logic [31:0] rdata);
        @(posedge clk_i);
        #2;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        cpu_addr_i     = addr;
        cpu_data_i     = data;
        stalls = 0;
        @(negedge clk_i);
        while (cpu_stall_o && stalls < 100) begin
            stalls++;
            @(negedge clk_i);
        end
        rdata = cpu_data_o;
        @(posedge clk_i);
        #2;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    initial begin : stimulus
        int          st;
        int          f0;
        int          w0;
        int          waited;
        logic [31:0] rd;

        rst_i          = 1'b0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        cpu_addr_i     = 32'h0;
        cpu_data_i     = 32'h0;
        repeat (3) @(negedge clk_i);
        check("rst_enable", 256'(mem_enable_o), 256'(0));
        check("rst_write",  256'(mem_write_o),  256'(0));
        check("rst_addr",   256'(mem_addr_o),   256'(0));
        check("rst_mdata",  mem_data_o,         256'(0));
        rst_i = 1'b1;
        @(negedge clk_i);
        check("idle_stall", 256'(cpu_stall_o), 256'(0));
        check("idle_data",  256'(cpu_data_o),  256'(0));

        // Cold load 0x40: clean miss.
        access(1'b1, 1'b0, 32'h40, 32'h0, st, rd);
        check("ld40_stall",  256'(st),         256'(L + 3));
        check("ld40_nfetch", 256'(n_fetch),    256'(1));
        check("ld40_faddr",  256'(fetch_addr), 256'(32'h40));
        check("ld40_nwb",    256'(n_wb),       256'(0));
        check("ld40_data",   256'(rd),         256'(32'h1000_0000));

        // Load 0x44: hit.
        access(1'b1, 1'b0, 32'h44, 32'h0, st, rd);
        check("ld44_stall",  256'(st),           256'(0));
        check("ld44_data",   256'(rd),           256'(32'h1000_0001));
        check("ld44_nfetch", 256'(n_fetch),      256'(1));
        check("ld44_en",     256'(mem_enable_o), 256'(0));

        // Store hit then read back.
        access(1'b0, 1'b1, 32'h48, 32'hDEAD_BEEF, st, rd);
        check("st48_stall", 256'(st), 256'(0));
        check("st48_wdata", 256'(rd), 256'(0));
        access(1'b1, 1'b0, 32'h48, 32'h0, st, rd);
        check("ld48_data",  256'(rd), 256'(32'hDEAD_BEEF));
        access(1'b1, 1'b0, 32'h4C, 32'h0, st, rd);
        check("ld4c_data",  256'(rd), 256'(32'h1000_0003));

        // Conflict load 0x240: dirty victim written back then fetched.
        access(1'b1, 1'b0, 32'h240, 32'h0, st, rd);
        check("ld240_stall",  256'(st),            256'(2 * L + 4));
        check("ld240_nwb",    256'(n_wb),          256'(1));
        check("ld240_wbaddr", 256'(wb_addr),       256'(32'h40));
        check("ld240_wbw2",   256'(wb_data[95:64]), 256'(32'hDEAD_BEEF));
        check("ld240_wbw0",   256'(wb_data[31:0]),  256'(32'h1000_0000));
        check("ld240_wbw7",   256'(wb_data[255:224]), 256'(32'h1000_0007));
        check("ld240_nfetch", 256'(n_fetch),       256'(2));
        check("ld240_faddr",  256'(fetch_addr),    256'(32'h240));
        check("ld240_data",   256'(rd),            256'(32'h1002_0000));

        // Store to a cold line: fetch then merge.
        access(1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, st, rd);
        check("st100_stall", 256'(st),         256'(L + 3));
        check("st100_faddr", 256'(fetch_addr), 256'(32'h100));
        access(1'b1, 1'b0, 32'h100, 32'h0, st, rd);
        check("ld100_data",  256'(rd), 256'(32'hCAFE_F00D));
        access(1'b1, 1'b0, 32'h108, 32'h0, st, rd);
        check("ld108_data",  256'(rd), 256'(32'h1001_4002));
        // Evicting it shows the dirty bit and the untouched words.
        access(1'b1, 1'b0, 32'h300, 32'h0, st, rd);
        check("ld300_stall",  256'(st),      256'(2 * L + 4));
        check("ld300_wbaddr", 256'(wb_addr), 256'(32'h100));
        check("ld300_wbdata", wb_data,
              {32'h1001_4007, 32'h1001_4006, 32'h1001_4005, 32'h1001_4004,
               32'h1001_4003, 32'h1001_4002, 32'h1001_4001, 32'hCAFE_F00D});
        check("ld300_data",   256'(rd),      256'(32'h1003_4000));

        // Refill 0x40 (victim 0x240 is clean).
        access(1'b1, 1'b0, 32'h40, 32'h0, st, rd);
        check("re40_stall", 256'(st),   256'(L + 3));
        check("re40_nwb",   256'(n_wb), 256'(2));
        check("re40_data",  256'(rd),   256'(32'h1000_0000));

        // Reset during READMISS of a cold load.
        f0 = n_fetch;
        w0 = n_wb;
        @(posedge clk_i);
        #2;
        cpu_MemRead_i = 1'b1;
        cpu_addr_i    = 32'h20;
        waited = 0;
        @(negedge clk_i);
        while (!mem_enable_o && waited < 20) begin
            waited++;
            @(negedge clk_i);
        end
        check("rm_en_high", 256'(mem_enable_o), 256'(1));
        rst_i = 1'b0;
        #1;
        check("rm_en_drop",  256'(mem_enable_o), 256'(0));
        check("rm_addr_clr", 256'(mem_addr_o),   256'(0));
        cpu_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rm_idle_en",  256'(mem_enable_o), 256'(0));
        check("rm_nfetch",   256'(n_fetch),      256'(f0 + 1));
        access(1'b1, 1'b0, 32'h40, 32'h0, st, rd);
        check("post_rst_stall", 256'(st),   256'(L + 3));
        check("post_rst_nwb",   256'(n_wb), 256'(w0));
        check("post_rst_data",  256'(rd),   256'(32'h1000_0000));

        @(negedge clk_i);
        check("end_stall",    256'(cpu_stall_o), 256'(0));
        check("end_data",     256'(cpu_data_o),  256'(0));
        check("req_stable",   256'(n_unstable),  256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller serving the MEM stage. Accepts the registered MEM-stage access (read/write enable, ALU-result address, RS2 store data) and returns load data. Drives `cpu_stall_o` high on a miss, freezing the pipeline registers until the line is filled. Talks to off-chip data memory through a 256-bit line-wide request/acknowledge interface.

## Interface
- `LINES`, 16: number of cache lines; index width is log2(LINES) = 4.
- `LINE_BITS`, 256: line size in bits (32 bytes, 8 words); offset is addr[4:0].
- `clk_i` in 1: clock; all state updates on posedge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `cpu_MemRead_i` in 1: load request from the MEM stage.
- `cpu_MemWrite_i` in 1: store request; never asserted together with read.
- `cpu_addr_i` in 32: byte address; tag=[31:9], index=[8:5], word=[4:2].
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data; valid when read request and `cpu_stall_o`=0.
- `cpu_stall_o` out 1: pipeline stall.
- `mem_enable_o` out 1: memory request, held until ack.
- `mem_write_o` out 1: 1 = line write-back, 0 = line fetch.
- `mem_addr_o` out 32: line address, bits [4:0] always 0.
- `mem_data_o` out 256: victim line for write-back.
- `mem_data_i` in 256: fetched line; sampled in the ack cycle.
- `mem_ack_i` in 1: single-cycle completion pulse.

## Operation
- Storage per line: valid, dirty, 23-bit tag, 256-bit data. Reset clears all valid and dirty bits; tag/data need no reset.
- hit = valid[index] && tag[index]==addr tag. req = MemRead || MemWrite.
- `cpu_stall_o` = req && !hit, combinational, in every state.
- Read hit: `cpu_data_o` = word [addr[4:2]] of the line, combinational. Otherwise `cpu_data_o` = 0.
- Write hit: the posedge writes the word into the line and sets dirty. Other words in the line are unchanged.
- FSM states:
  - IDLE: on req && !hit, go to MISS.
  - MISS: if the victim is valid and dirty, go to WRITEBACK and issue a write with addr = {victim tag, index, 5'b0} and `mem_data_o` = victim line. Otherwise go to READMISS and issue a read with addr = {req tag, index, 5'b0}.
  - WRITEBACK: hold the request. On `mem_ack_i`, clear dirty, go to READMISS and issue the fetch.
  - READMISS: hold the request. On `mem_ack_i`, write `mem_data_i` into the line, set tag, valid=1, dirty=0, deassert `mem_enable_o`, and go to READMISSOK.
  - READMISSOK: go to IDLE. The request now hits, and a pending store merges into the line on that cycle's hit path.
- `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are registered. They are stable for the whole transaction.
- Address and data inputs must remain stable while stalled; the pipeline registers guarantee this.

## Timing
- Reset values: FSM=IDLE; `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0. `cpu_stall_o` and `cpu_data_o` are 0 with no request.
- Hits have zero added latency: no stall cycle.
- Clean miss with memory latency L (ack L cycles after enable rises):
  - IDLE→MISS: 1 cycle.
  - Enable rises on MISS exit.
  - Ack, then READMISSOK: 1 cycle.
  - Stall is high for L+3 cycles.
- Dirty miss: adds the write-back latency L plus 1 cycle.
- The memory may ack at the earliest one cycle after enable rises. An ack outside WRITEBACK/READMISS is ignored.
- Reset asserted mid-transaction: immediate return to IDLE, enable dropped, all lines invalid. The outstanding memory transaction is abandoned.

## Test plan
- After reset, load 0x0000_0040 with memory line = word k = 0x1000_0000+k. Required: stall for L+3 cycles, one fetch at 0x40, then `cpu_data_o` = 0x1000_0000.
- Load 0x44 immediately after: hit, no stall, data 0x1000_0001, `mem_enable_o` stays 0.
- Store 0xDEAD_BEEF to 0x48 (hit): no stall, dirty set. A following load from 0x48 returns 0xDEAD_BEEF.
- Load 0x0000_0240 (same index 2, different tag):
  - write-back at 0x40 with word 2 = 0xDEAD_BEEF;
  - then fetch at 0x240;
  - stall covers both transactions.
- Store to a cold line 0x0000_0100: one fetch, then the word merges. The line is dirty, and its other 7 words equal the memory contents.
- Drive `rst_i` low during READMISS: enable drops asynchronously, FSM returns to IDLE, and the next access to the previously filled 0x40 misses.
